// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: serialises 16-bit mono PCM into an I2S stream for the codec DAC
// and generates BCLK / DACLRCK from the system clock. The same sample is sent in
// both slots. Idles in WAIT until codec configuration completes.
// Build option: define I2S_DAC_TX_LJ_EN for left-justified output (no one-bit delay).
module i2s_dac_tx #(
    parameter int BCLK_HALF     = 8,
    parameter int DATA_OVER_LEN = 41
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        INIT_FINISH,
    input  logic [15:0] sample_in,
    output logic        data_over,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int DIV_W = $clog2(BCLK_HALF);
    localparam int DO_W  = $clog2(DATA_OVER_LEN + 1);

    typedef enum logic {StWait, StRun} state_e;

    state_e             r_state;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [5:0]         r_bit_cnt;
    logic [15:0]        r_sample;
    logic [DO_W-1:0]    r_do_cnt;
    logic               r_data_over;
    logic               r_bclk;
    logic               r_lrck;
    logic               r_dacdat;

    logic               w_div_top;
    logic [5:0]         w_bit_nxt;
    logic               w_wrap;
    logic [15:0]        w_sample_nxt;

    // Serial bit for slot position k of word s.
    function automatic logic f_dat(input logic [15:0] s, input logic [4:0] k);
        logic [3:0] idx;
        f_dat = 1'b0;
`ifdef I2S_DAC_TX_LJ_EN
        idx = 4'(5'd15 - k);
        if (k <= 5'd15) f_dat = s[idx];
`else
        idx = 4'(5'd16 - k);
        if (k >= 5'd1 && k <= 5'd16) f_dat = s[idx];
`endif
    endfunction

    // Next-state helpers; a wrap reloads the sample, so the k=0 bit must use the new word.
    always_comb begin
        w_div_top    = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
        w_bit_nxt    = r_bit_cnt + 6'd1;
        w_wrap       = (r_bit_cnt == 6'd63);
        w_sample_nxt = w_wrap ? sample_in : r_sample;
    end

    // FSM, clock generation, serialiser and data_over stretch, all registered.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= StWait;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_sample    <= '0;
            r_do_cnt    <= '0;
            r_data_over <= 1'b0;
            r_bclk      <= 1'b0;
            r_lrck      <= 1'b0;
            r_dacdat    <= 1'b0;
        end else begin
            case (r_state)
                StWait: begin
                    if (INIT_FINISH) begin
                        r_state     <= StRun;
                        r_sample    <= sample_in;
                        r_data_over <= 1'b1;
                        r_do_cnt    <= DO_W'(DATA_OVER_LEN - 1);
                        r_dacdat    <= f_dat(sample_in, 5'd0);
                    end
                end
                StRun: begin
                    // Remaining-cycles counter; a new latch below overrides this.
                    if (r_do_cnt != '0) begin
                        r_do_cnt <= r_do_cnt - DO_W'(1);
                    end else begin
                        r_data_over <= 1'b0;
                    end
                    if (w_div_top) begin
                        r_div_cnt <= '0;
                        r_bclk    <= ~r_bclk;
                        if (r_bclk) begin
                            // Falling edge: advance the bit position and present the next bit.
                            r_bit_cnt <= w_bit_nxt;
                            r_lrck    <= w_bit_nxt[5];
                            r_dacdat  <= f_dat(w_sample_nxt, w_bit_nxt[4:0]);
                            if (w_wrap) begin
                                r_sample    <= sample_in;
                                r_data_over <= 1'b1;
                                r_do_cnt    <= DO_W'(DATA_OVER_LEN - 1);
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: r_state <= StWait;
            endcase
        end
    end

    assign data_over   = r_data_over;
    assign AUD_BCLK    = r_bclk;
    assign AUD_DACLRCK = r_lrck;
    assign AUD_DACDAT  = r_dacdat;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed vectors against a captured trace of three frames,
// plus sequences for reset/WAIT, mid-frame reset and restart.
module tb_i2s_dac_tx;

    localparam int BH    = 8;
    localparam int DOL   = 41;
    localparam int FRAME = 128 * BH;
    localparam int NTR   = 3 * FRAME;
`ifdef I2S_DAC_TX_LJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        INIT_FINISH;
    logic [15:0] sample_in;
    logic        data_over;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;

    i2s_dac_tx #(
        .BCLK_HALF    (BH),
        .DATA_OVER_LEN(DOL)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .INIT_FINISH(INIT_FINISH),
        .sample_in  (sample_in),
        .data_over  (data_over),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT (AUD_DACDAT)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int   off;
        logic bclk;
        logic lrck;
        logic dat_i2s;
        logic dat_lj;
        logic dov;
    } vec_t;

    vec_t vecs [17];
    logic tr_bclk [NTR];
    logic tr_lrck [NTR];
    logic tr_dat  [NTR];
    logic tr_dov  [NTR];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({data_over, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT});
    endfunction

    initial begin
        int bad;
        int nrise, first_rise, last_rise;
        int nfall, fall0, fall1;
        int dov_rises [$];
        int dov_high;
        logic [31:0] pat, exp_pat;
        logic [15:0] w;

        // off, bclk, lrck, dat (I2S), dat (LJ), data_over; A5C3 frames 0-1, 8001 frame 2
        vecs[0]  = '{0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{7,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{8,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{16,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{40,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{41,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{248,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{264,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{280,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{520,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{536,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1023, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1064, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1065, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{2048, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{2064, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset and WAIT
        Reset_n     = 1'b0;
        INIT_FINISH = 1'b0;
        sample_in   = 16'h0000;
        repeat (5) @(negedge Clk);
        chk("reset_outs", outs(), 0);
        Reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (outs() != 0) bad++;
        end
        chk("wait_idle", bad, 0);

        // Start-up and capture three frames; INIT_FINISH drops in RUN, sample changes in frame 1
        sample_in   = 16'hA5C3;
        INIT_FINISH = 1'b1;
        @(posedge Clk);
        for (int t = 0; t < NTR; t++) begin
            @(negedge Clk);
            tr_bclk[t] = AUD_BCLK;
            tr_lrck[t] = AUD_DACLRCK;
            tr_dat[t]  = AUD_DACDAT;
            tr_dov[t]  = data_over;
            if (t == 0) INIT_FINISH = 1'b0;
            if (t == 1500) sample_in = 16'h8001;
        end

        for (int i = 0; i < 17; i++) begin
            chk($sformatf("v%0d_bclk@%0d", i, vecs[i].off), int'(tr_bclk[vecs[i].off]),
                int'(vecs[i].bclk));
            chk($sformatf("v%0d_lrck@%0d", i, vecs[i].off), int'(tr_lrck[vecs[i].off]),
                int'(vecs[i].lrck));
            chk($sformatf("v%0d_dat@%0d", i, vecs[i].off), int'(tr_dat[vecs[i].off]),
                int'(LJ ? vecs[i].dat_lj : vecs[i].dat_i2s));
            chk($sformatf("v%0d_dov@%0d", i, vecs[i].off), int'(tr_dov[vecs[i].off]),
                int'(vecs[i].dov));
        end

        // Slot contents sampled mid-bit (BCLK high), k=0 at pattern bit 31
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 2; s++) begin
                bad = 0;
                for (int k = 0; k < 32; k++) begin
                    pat[31-k] = tr_dat[f*FRAME + s*(FRAME/2) + k*2*BH + BH];
                    if (tr_lrck[f*FRAME + s*(FRAME/2) + k*2*BH + BH] != s[0]) bad++;
                end
                w = (f < 2) ? 16'hA5C3 : 16'h8001;
                exp_pat = LJ ? {w, 16'h0000} : {1'b0, w, 15'h0000};
                chk($sformatf("slot_f%0d_s%0d", f, s), int'(pat), int'(exp_pat));
                chk($sformatf("lrck_f%0d_s%0d", f, s), bad, 0);
            end
        end

        // BCLK: first rise at 8, period 16
        nrise = 0; first_rise = -1; last_rise = -1; bad = 0;
        for (int t = 1; t < NTR; t++) begin
            if (tr_bclk[t] && !tr_bclk[t-1]) begin
                if (first_rise < 0) first_rise = t;
                else if (t - last_rise != 2 * BH) bad++;
                last_rise = t;
                nrise++;
            end
        end
        chk("bclk_first_rise", first_rise, BH);
        chk("bclk_period_bad", bad, 0);
        chk("bclk_rises", nrise, NTR / (2 * BH));

        // DACLRCK falls once per frame
        nfall = 0; fall0 = -1; fall1 = -1;
        for (int t = 1; t < NTR; t++) begin
            if (!tr_lrck[t] && tr_lrck[t-1]) begin
                if (nfall == 0) fall0 = t;
                if (nfall == 1) fall1 = t;
                nfall++;
            end
        end
        chk("lrck_falls", nfall, 2);
        chk("lrck_fall0", fall0, FRAME);
        chk("lrck_period", fall1 - fall0, FRAME);

        // data_over: rises with each frame start, DOL cycles each
        dov_high = 0;
        for (int t = 0; t < NTR; t++) begin
            if (tr_dov[t]) dov_high++;
            if (tr_dov[t] && (t == 0 || !tr_dov[t-1])) dov_rises.push_back(t);
        end
        chk("dov_rises", dov_rises.size(), 3);
        for (int i = 0; i < dov_rises.size(); i++)
            chk($sformatf("dov_rise%0d", i), dov_rises[i], i * FRAME);
        chk("dov_high_total", dov_high, 3 * DOL);

        // Data only changes on BCLK falling edges
        bad = 0;
        for (int t = 1; t < NTR; t++)
            if (tr_dat[t] != tr_dat[t-1] && !(tr_bclk[t-1] && !tr_bclk[t])) bad++;
        chk("dat_change_on_fall", bad, 0);

        // Mid-frame reset in slot R, k=7 (offset 3700)
        for (int t = NTR; t <= 3700; t++) @(negedge Clk);
        chk("pre_reset_lrck", int'(AUD_DACLRCK), 1);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("midreset_outs", outs(), 0);
        Reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (outs() != 0) bad++;
        end
        chk("postreset_wait_idle", bad, 0);

        // Restart needs INIT_FINISH again
        INIT_FINISH = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("restart_dov", int'(data_over), 1);
        INIT_FINISH = 1'b0;
        repeat (BH - 1) @(negedge Clk);
        chk("restart_bclk_low@7", int'(AUD_BCLK), 0);
        @(negedge Clk);
        chk("restart_bclk_high@8", int'(AUD_BCLK), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Serialises 16-bit mono PCM samples into an I2S stream for the board audio codec DAC, and generates the codec's bit clock and left/right clock from the system clock. It sits directly downstream of the sample-ROM address generator. It consumes the ROM word at that generator's current address. It returns `data_over` to tell the generator the sample has been taken and the next address may be issued. The block idles until the codec configuration sequence reports completion.

## Interface
Parameters:
- `BCLK_HALF`, 8: Clk cycles per BCLK half-period; must be ≥ 2.
- `DATA_OVER_LEN`, 41: Clk cycles `data_over` stays high per sample; must be ≥ 1 and < 128·`BCLK_HALF`.

Ports:
- `Clk`, in, 1: system clock (50 MHz).
- `Reset_n`, in, 1: synchronous, active-low reset.
- `INIT_FINISH`, in, 1: codec configuration complete.
- `sample_in`, in, 16: signed PCM sample from the ROM.
- `data_over`, out, 1: sample latched; upstream may advance its address.
- `AUD_BCLK`, out, 1: I2S bit clock.
- `AUD_DACLRCK`, out, 1: left/right clock; low = left, high = right.
- `AUD_DACDAT`, out, 1: serial data, MSB first.

## Operation
- State machine has two states, WAIT and RUN.
  - WAIT to RUN on any cycle with `INIT_FINISH`=1.
  - RUN is left only by reset. `INIT_FINISH` falling in RUN is ignored.
- In WAIT, all outputs are 0 and all counters are held at 0.
- Counters:
  - `div_cnt` counts 0..`BCLK_HALF`-1. When it reaches the top it wraps to 0 and `AUD_BCLK` toggles.
  - `bit_cnt` is 6 bits, 0..63. It advances, wrapping 63 to 0, only on toggles that drive `AUD_BCLK` low (falling edges).
- Frame layout:
  - A frame is 64 BCLK periods: slot L is `bit_cnt` 0..31, slot R is 32..63.
  - `AUD_DACLRCK` = `bit_cnt`[5].
  - Let k = `bit_cnt`[4:0]. `AUD_DACDAT` = `sample_reg`[16-k] for k=1..16, otherwise 0. This is the standard I2S one-bit delay.
  - The same `sample_reg` is sent in both slots (mono duplicated).
- Sample latch: `sample_reg` loads `sample_in` on the WAIT-to-RUN transition edge and on every falling-edge toggle where `bit_cnt` wraps 63 to 0.
- `data_over`:
  - Goes high on the same edge as each latch and stays high for exactly `DATA_OVER_LEN` Clk cycles.
  - The stretch covers an upstream that samples `data_over` once every ≤41 cycles.
  - A new latch while the stretch is active restarts the stretch (unreachable with legal parameters).
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Timing
- Reset: on a Clk edge with `Reset_n`=0, the state goes to WAIT and every output, counter and `sample_reg` goes to 0. This applies mid-frame as well; there is no frame completion.
- Let T be the first cycle in RUN:
  - `data_over`=1 for cycles T..T+`DATA_OVER_LEN`-1.
  - `AUD_BCLK` first rises at cycle T+`BCLK_HALF` and first falls at T+2·`BCLK_HALF`.
- `AUD_DACDAT`, `AUD_DACLRCK` and `bit_cnt` update on the same Clk edge that drives `AUD_BCLK` low. Data is therefore stable for a full BCLK period around each rising edge.
- Frame period = 128·`BCLK_HALF` Clk cycles. With defaults that is 1024 cycles, i.e. 48.83 kHz at 50 MHz.
- Sample latency: `sample_in` present at a latch edge has its MSB on `AUD_DACDAT` after exactly one BCLK period, i.e. 2·`BCLK_HALF` Clk cycles.
- `sample_in` must be stable on the latch edge. Upstream ROM latency is absorbed by the frame-long hold.

## Configuration
- `I2S_DAC_TX_LJ_EN` defined: left-justified format with no one-bit delay. `AUD_DACDAT` = `sample_reg`[15-k] for k=0..15, otherwise 0.
- Undefined: standard I2S format as described in Operation.
- Port list, clocking and `data_over` behaviour are identical in both builds.

## Test plan
- Reset and WAIT:
  - Hold `Reset_n`=0 for 5 cycles, then release with `INIT_FINISH`=0 for 200 cycles.
  - Required: all outputs stay 0 and `AUD_BCLK` never toggles.
- Start-up:
  - Raise `INIT_FINISH` with `sample_in`=16'hA5C3.
  - Required: `data_over` is high for exactly 41 cycles starting at the first RUN cycle. `AUD_BCLK` rises 8 cycles after RUN entry. The serial bits for k=1..16 read 1010010111000011 in both slots.
- Frame timing:
  - Run 3 frames.
  - Required: `AUD_BCLK` period is 16 cycles and `AUD_DACLRCK` period is 1024 cycles. `data_over` rises every 1024 cycles, aligned with the `AUD_DACLRCK` falling edge. `AUD_DACDAT`=0 for k=0 and for k=17..31.
- Sample update:
  - Change `sample_in` to 16'h8001 mid-frame.
  - Required: the current frame still sends 16'hA5C3. The next frame sends 1000000000000001 in both slots.
- Mid-frame reset:
  - Drive `Reset_n`=0 during slot R with bit k=7.
  - Required: all outputs are 0 on the next edge. After release, operation restarts from WAIT and needs `INIT_FINISH` again to re-enter RUN.
- Left-justified build:
  - With `I2S_DAC_TX_LJ_EN` defined, send 16'hA5C3.
  - Required: the MSB appears at k=0 and `AUD_DACDAT`=0 for k=16..31.
